// File: rtl/coef_rom_scheduler_pkg.sv
// Shared definitions for the coefficient ROM scheduler: address width,
// default data width / read latency and the sequencing state encodings.
package coef_rom_scheduler_pkg;

  localparam int ADDR_W       = 6;
  localparam int DATA_W_DEF   = 16;
  localparam int READ_LAT_DEF = 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND_ADDR = 3'd1,
    S_ACT_RE    = 3'd2,
    S_WAIT_DATA = 3'd3,
    S_DELIVER   = 3'd4
  } state_t;

endpackage

// File: rtl/coef_rom_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer remembers the requester served
// last; on contention the other one wins. The pointer resets to requester 1
// so requester 0 wins the first contention after reset.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic any_req,
  output logic winner
);

  logic last_q;

  // Winner select: a lone request wins, contention goes to the non-last one.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      winner = ~last_q;
    end else begin
      winner = req1;
    end
  end

  // Pointer update on every accepted arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (advance && any_req) begin
      last_q <= winner;
    end
  end

endmodule

// File: rtl/coef_rom_scheduler.sv
// Coefficient ROM scheduler: shares one coefficient memory between the
// forward (0) and inverse (1) DCT requesters.
//
// Handshake: a requester holds ReqN high with AddrN stable until it sees
// GrantN (one cycle); request and address are consumed on the edge before
// GrantN, so both may change from the GrantN cycle on. A request dropped
// before it is granted is forgotten. ValidN is a one-cycle pulse qualifying
// Data_Out, which then holds its value until the next memory capture.
// READ_LAT must be in 1..7 (it is loaded into a 3-bit counter).
module coef_rom_scheduler
  import coef_rom_scheduler_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Req0,
  input  logic              Req1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Mem_Data,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic              Mem_Read_Enable,
  output logic              Grant0,
  output logic              Grant1,
  output logic              Valid0,
  output logic              Valid1,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Busy,
  output state_t            Dbg_State
);

  localparam logic [2:0] LAT_LOAD = 3'(READ_LAT);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q;
  logic                sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                arb_phase;
  logic                any_req;
  logic                winner;
  logic                capture;

  assign arb_phase = (state_q == S_IDLE) || (state_q == S_DELIVER);
  assign capture   = (state_q == S_WAIT_DATA) && (cnt_q == 3'd1);

  rr_arbiter2 u_arb (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .req0    (Req0),
    .req1    (Req1),
    .advance (arb_phase),
    .any_req (any_req),
    .winner  (winner)
  );

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes; unknown encodings fall back to idle, strobes low.
  always_comb begin
    state_d         = S_IDLE;
    Grant0          = 1'b0;
    Grant1          = 1'b0;
    Valid0          = 1'b0;
    Valid1          = 1'b0;
    Mem_Read_Enable = 1'b0;
    Busy            = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = any_req ? S_SEND_ADDR : S_IDLE;
      end
      S_SEND_ADDR: begin
        Busy    = 1'b1;
        Grant0  = ~sel_q;
        Grant1  = sel_q;
        state_d = S_ACT_RE;
      end
      S_ACT_RE: begin
        Busy            = 1'b1;
        Mem_Read_Enable = 1'b1;
        state_d         = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        Busy    = 1'b1;
        state_d = capture ? S_DELIVER : S_WAIT_DATA;
      end
      S_DELIVER: begin
        Busy    = 1'b1;
        Valid0  = ~sel_q;
        Valid1  = sel_q;
        state_d = any_req ? S_SEND_ADDR : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read-latency counter: loaded while the read strobe is out, counts down in wait.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= 3'd0;
    end else if (state_q == S_ACT_RE) begin
      cnt_q <= LAT_LOAD;
    end else if (state_q == S_WAIT_DATA) begin
      cnt_q <= cnt_q - 3'd1;
    end else begin
      cnt_q <= 3'd0;
    end
  end

  // Winner index and address latched on the arbitration edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sel_q  <= 1'b0;
      addr_q <= '0;
    end else if (arb_phase && any_req) begin
      sel_q  <= winner;
      addr_q <= winner ? Addr1 : Addr0;
    end
  end

  // Read data captured on the edge that leaves the wait state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      data_q <= '0;
    end else if (capture) begin
      data_q <= Mem_Data;
    end
  end

  assign Mem_Address = addr_q;
  assign Data_Out    = data_q;
  assign Dbg_State   = state_q;

endmodule
